// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// video_timing_gen : 640x480@60 raster timing with RGB888 stream alignment,
//                    feeding the three TMDS channel encoders.
// Optional macro VTG_COLOR_BARS_EN adds pattern_sel (8 vertical colour bars).
// Revision: 1.0 - initial release
// ============================================================================
module video_timing_gen #(
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic HS_POL   = 1'b0,
   parameter logic VS_POL   = 1'b0
) (
   input  logic        PixelClk,
   input  logic        aRst_n,
   input  logic [23:0] in_data,
   input  logic        in_valid,
   input  logic        in_sof,
`ifdef VTG_COLOR_BARS_EN
   input  logic        pattern_sel,
`endif
   output logic        in_ready,
   output logic [7:0]  out_red,
   output logic [7:0]  out_green,
   output logic [7:0]  out_blue,
   output logic        out_hsync,
   output logic        out_vsync,
   output logic        out_vde,
   output logic        frame_start,
   output logic        underflow,
   output logic        lock
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
   localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
   localparam logic [10:0] V_ACT   = 11'(V_ACTIVE);
   localparam logic [10:0] HS_BEG  = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] VS_BEG  = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END  = 11'(V_ACTIVE + V_FP + V_SYNC);

   typedef enum logic [0:0] {
      WAIT_SOF = 1'b0,
      LOCKED   = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [10:0] h_cnt_q, h_cnt_d;
   logic [10:0] v_cnt_q, v_cnt_d;
   logic [23:0] pix_q, pix_d;
   logic        hs_q, vs_q, vde_q;
   logic        fs_q, fs_d;
   logic        uf_q, uf_d;
   logic        active, origin, hs_act, vs_act;

   assign active = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
   assign origin = (h_cnt_q == 11'd0) && (v_cnt_q == 11'd0);
   assign hs_act = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
   assign vs_act = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);

   always_comb begin
      h_cnt_d = h_cnt_q + 11'd1;
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == H_LAST) begin
         h_cnt_d = 11'd0;
         v_cnt_d = (v_cnt_q == V_LAST) ? 11'd0 : v_cnt_q + 11'd1;
      end
   end

`ifdef VTG_COLOR_BARS_EN
   logic [2:0]  bar_idx;
   logic [23:0] bar_rgb;

   always_comb begin
      bar_idx = 3'd0;
      for (int i = 1; i < 8; i++) begin
         if (h_cnt_q >= 11'(i * (H_ACTIVE / 8))) begin
            bar_idx = 3'(i);
         end
      end
   end

   // Bar order W,Y,C,G,M,R,B,K falls out of inverted index bits: R=~b1, G=~b2, B=~b0
   assign bar_rgb = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
`endif

   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      pix_d    = 24'h000000;
      fs_d     = 1'b0;
      uf_d     = 1'b0;
      case (state_q)
         WAIT_SOF: begin
            in_ready = in_valid && !in_sof;
            if (origin && in_valid && in_sof) begin
               in_ready = 1'b1;
               pix_d    = in_data;
               fs_d     = 1'b1;
               state_d  = LOCKED;
            end
         end
         LOCKED: begin
            in_ready = active;
            if (active) begin
               if (!in_valid) begin
                  uf_d    = 1'b1;
                  state_d = WAIT_SOF;
               end else begin
                  pix_d = in_data;
                  // SOF must coincide exactly with the raster origin to stay locked
                  if (in_sof != origin) begin
                     uf_d    = 1'b1;
                     state_d = WAIT_SOF;
                  end else if (origin) begin
                     fs_d = 1'b1;
                  end
               end
            end
         end
         default: state_d = WAIT_SOF;
      endcase
`ifdef VTG_COLOR_BARS_EN
      if (pattern_sel) begin
         state_d  = WAIT_SOF;
         in_ready = 1'b0;
         fs_d     = 1'b0;
         uf_d     = 1'b0;
         pix_d    = active ? bar_rgb : 24'h000000;
      end
`endif
   end

   always_ff @(posedge PixelClk or negedge aRst_n) begin
      if (!aRst_n) begin
         state_q <= WAIT_SOF;
         h_cnt_q <= 11'd0;
         v_cnt_q <= 11'd0;
         pix_q   <= 24'h000000;
         hs_q    <= ~HS_POL;
         vs_q    <= ~VS_POL;
         vde_q   <= 1'b0;
         fs_q    <= 1'b0;
         uf_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
         pix_q   <= pix_d;
         hs_q    <= hs_act ? HS_POL : ~HS_POL;
         vs_q    <= vs_act ? VS_POL : ~VS_POL;
         vde_q   <= active;
         fs_q    <= fs_d;
         uf_q    <= uf_d;
      end
   end

   assign out_red     = pix_q[23:16];
   assign out_green   = pix_q[15:8];
   assign out_blue    = pix_q[7:0];
   assign out_hsync   = hs_q;
   assign out_vsync   = vs_q;
   assign out_vde     = vde_q;
   assign frame_start = fs_q;
   assign underflow   = uf_q;
   assign lock        = (state_q == LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
// tb_video_timing_gen : scoreboard bench for video_timing_gen (reduced raster
//                       instance plus a full 640x480 instance for line timing).
// Revision: 1.0 - initial release
// ============================================================================
module tb_video_timing_gen;

   localparam int HA = 16, HF = 2, HSW = 4, HB = 3;
   localparam int VA = 8,  VF = 2, VSW = 2, VB = 3;
   localparam int HT = HA + HF + HSW + HB;
   localparam int VT = VA + VF + VSW + VB;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [23:0] in_data;
   logic        in_valid, in_sof, in_ready;
   logic [7:0]  out_red, out_green, out_blue;
   logic        out_hsync, out_vsync, out_vde, frame_start, underflow, lock;
`ifdef VTG_COLOR_BARS_EN
   logic        pattern_sel;
   logic        b_ps;
`endif

   video_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
      .HS_POL(1'b0), .VS_POL(1'b0)
   ) dut (
      .PixelClk(clk), .aRst_n(rst_n),
      .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
`ifdef VTG_COLOR_BARS_EN
      .pattern_sel(pattern_sel),
`endif
      .in_ready(in_ready),
      .out_red(out_red), .out_green(out_green), .out_blue(out_blue),
      .out_hsync(out_hsync), .out_vsync(out_vsync), .out_vde(out_vde),
      .frame_start(frame_start), .underflow(underflow), .lock(lock)
   );

   logic        rstb_n;
   logic [23:0] b_data;
   logic        b_valid, b_sof, b_ready;
   logic [7:0]  b_r, b_g, b_b;
   logic        b_hs, b_vs, b_vde, b_fs, b_uf, b_lk;

   video_timing_gen dut_full (
      .PixelClk(clk), .aRst_n(rstb_n),
      .in_data(b_data), .in_valid(b_valid), .in_sof(b_sof),
`ifdef VTG_COLOR_BARS_EN
      .pattern_sel(b_ps),
`endif
      .in_ready(b_ready),
      .out_red(b_r), .out_green(b_g), .out_blue(b_b),
      .out_hsync(b_hs), .out_vsync(b_vs), .out_vde(b_vde),
      .frame_start(b_fs), .underflow(b_uf), .lock(b_lk)
   );

   typedef struct {
      int          cyc;
      logic [23:0] pix;
      logic        hs, vs, vde, fs, uf, lk;
   } exp_t;
   typedef struct {
      int   cyc;
      logic rdy;
   } rdy_t;

   exp_t q_out[$];
   rdy_t q_rdy[$];
   exp_t me;
   rdy_t mr;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0, failures = 0;
   int mh = 0, mv = 0;
   bit mlock = 1'b0;
   int drop_x = -1, drop_y = -1, bad_x = -1, bad_y = -1;
   bit big_done = 1'b0;

   function automatic logic [23:0] bar(input int x);
      case (x / (HA / 8))
         0:       return 24'hFFFFFF;
         1:       return 24'hFFFF00;
         2:       return 24'h00FFFF;
         3:       return 24'h00FF00;
         4:       return 24'hFF00FF;
         5:       return 24'hFF0000;
         6:       return 24'h0000FF;
         default: return 24'h000000;
      endcase
   endfunction

   // Drive one cycle, queue what the DUT must show, then advance one clock.
   task automatic step(input logic v, input logic s, input logic [23:0] d, input logic ps);
      exp_t e;
      rdy_t r;
      logic act, org, rdy;
      bit   nlock;
      in_valid = v; in_sof = s; in_data = d;
`ifdef VTG_COLOR_BARS_EN
      pattern_sel = ps;
`endif
      act = (mh < HA) && (mv < VA);
      org = (mh == 0) && (mv == 0);
      e.cyc = cyc + 1; e.pix = 24'h0; e.fs = 1'b0; e.uf = 1'b0; e.vde = act;
      e.hs = !((mh >= HA + HF) && (mh < HA + HF + HSW));
      e.vs = !((mv >= VA + VF) && (mv < VA + VF + VSW));
      nlock = mlock;
      rdy = 1'b0;
      if (ps) begin
         nlock = 1'b0;
         if (act) e.pix = bar(mh);
      end else if (!mlock) begin
         rdy = v && !s;
         if (org && v && s) begin
            rdy = 1'b1; e.pix = d; e.fs = 1'b1; nlock = 1'b1;
         end
      end else begin
         rdy = act;
         if (act) begin
            if (!v) begin
               e.uf = 1'b1; nlock = 1'b0;
            end else begin
               e.pix = d;
               if (s != org) begin
                  e.uf = 1'b1; nlock = 1'b0;
               end else if (org) begin
                  e.fs = 1'b1;
               end
            end
         end
      end
      e.lk = nlock;
      r.cyc = cyc; r.rdy = rdy;
      q_rdy.push_back(r);
      q_out.push_back(e);
      mlock = nlock;
      mh = mh + 1;
      if (mh == HT) begin
         mh = 0;
         mv = (mv == VT - 1) ? 0 : mv + 1;
      end
      @(posedge clk); #1;
   endtask

   task automatic do_reset(input int n);
      exp_t e;
      if (q_out.size() > 0 && q_out[$].cyc >= cyc) void'(q_out.pop_back());
      rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = 24'h0;
`ifdef VTG_COLOR_BARS_EN
      pattern_sel = 1'b0;
`endif
      mh = 0; mv = 0; mlock = 1'b0;
      for (int i = 0; i < n; i++) begin
         e.cyc = cyc; e.pix = 24'h0; e.hs = 1'b1; e.vs = 1'b1;
         e.vde = 1'b0; e.fs = 1'b0; e.uf = 1'b0; e.lk = 1'b0;
         q_out.push_back(e);
         @(posedge clk); #1;
      end
      rst_n = 1'b1;
   endtask

   task automatic stream(input int n, input logic ps);
      for (int i = 0; i < n; i++) begin
         logic v, s;
         logic [23:0] d;
         v = 1'b1;
         s = (mh == 0) && (mv == 0);
         d = {mh[7:0], mv[7:0], 8'hA5};
         if (mh == drop_x && mv == drop_y) begin v = 1'b0; drop_x = -1; end
         if (mh == bad_x && mv == bad_y) begin s = ~s; bad_x = -1; end
         step(v, s, d, ps);
      end
   endtask

   always @(negedge clk) begin
      while (q_out.size() > 0 && q_out[0].cyc <= cyc) begin
         me = q_out.pop_front();
         checks++;
         if (me.cyc != cyc ||
             {out_red, out_green, out_blue} !== me.pix || out_hsync !== me.hs ||
             out_vsync !== me.vs || out_vde !== me.vde || frame_start !== me.fs ||
             underflow !== me.uf || lock !== me.lk) begin
            failures++;
            $display("FAIL outputs cyc=%0d: got pix=%h hs=%b vs=%b vde=%b fs=%b uf=%b lk=%b, want pix=%h hs=%b vs=%b vde=%b fs=%b uf=%b lk=%b (slot %0d)",
                     cyc, {out_red, out_green, out_blue}, out_hsync, out_vsync, out_vde,
                     frame_start, underflow, lock, me.pix, me.hs, me.vs, me.vde,
                     me.fs, me.uf, me.lk, me.cyc);
         end
      end
      while (q_rdy.size() > 0 && q_rdy[0].cyc <= cyc) begin
         mr = q_rdy.pop_front();
         checks++;
         if (mr.cyc != cyc || in_ready !== mr.rdy) begin
            failures++;
            $display("FAIL in_ready cyc=%0d: got %b want %b (slot %0d)", cyc, in_ready, mr.rdy, mr.cyc);
         end
      end
   end

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         failures++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   // Full-size instance: two free-running lines of 640x480 timing.
   initial begin
      int first_vde, first_hs, vde_cnt, hs_cnt, vs_low, pix_nz, run, max_run;
      rstb_n = 1'b0; b_valid = 1'b0; b_sof = 1'b0; b_data = 24'h0;
`ifdef VTG_COLOR_BARS_EN
      b_ps = 1'b0;
`endif
      first_vde = -1; first_hs = -1; vde_cnt = 0; hs_cnt = 0;
      vs_low = 0; pix_nz = 0; run = 0; max_run = 0;
      repeat (2) @(posedge clk);
      #1;
      rstb_n = 1'b1;
      for (int i = 0; i < 1600; i++) begin
         @(negedge clk);
         if (b_vde === 1'b1) begin
            vde_cnt++;
            if (first_vde < 0) first_vde = i;
         end
         if (b_hs === 1'b0) begin
            hs_cnt++; run++;
            if (run > max_run) max_run = run;
            if (first_hs < 0) first_hs = i;
         end else begin
            run = 0;
         end
         if (b_vs !== 1'b1) vs_low++;
         if ({b_r, b_g, b_b} !== 24'h0) pix_nz++;
      end
      chk("full_first_vde", first_vde, 1);
      chk("full_vde_count", vde_cnt, 1280);
      chk("full_first_hsync", first_hs, 657);
      chk("full_hsync_count", hs_cnt, 192);
      chk("full_hsync_width", max_run, 96);
      chk("full_vsync_low", vs_low, 0);
      chk("full_pixels_nonzero", pix_nz, 0);
      big_done = 1'b1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = 24'h0;
`ifdef VTG_COLOR_BARS_EN
      pattern_sel = 1'b0;
`endif
      @(posedge clk); #1;
      do_reset(3);
      for (int i = 0; i < 420; i++) step(1'b0, 1'b0, 24'h0, 1'b0);
      // Lands inside the hsync pulse so reset visibly forces hsync inactive
      do_reset(2);
      for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 24'h0, 1'b0);
      stream(900, 1'b0);
      drop_x = 10; drop_y = 3;
      stream(1000, 1'b0);
      bad_x = 5; bad_y = 0;
      stream(1000, 1'b0);
      bad_x = 0; bad_y = 0;
      stream(1000, 1'b0);
`ifdef VTG_COLOR_BARS_EN
      stream(1000, 1'b1);
      stream(1000, 1'b0);
`endif
      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_drained", q_out.size() + q_rdy.size(), 0);
      for (int i = 0; i < 3000 && !big_done; i++) @(posedge clk);
      chk("full_instance_done", int'(big_done), 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Upstream neighbour of the per-channel TMDS encoders in the HDMI output path.
- Generates 640x480@60 raster timing: horizontal/vertical counters, hsync, vsync and video data enable.
- Pulls RGB888 pixels from the camera frame-buffer read stream through a valid/ready handshake and aligns them with timing.
- Outputs drive the three encoders: each colour byte goes to one encoder's pixel input; hsync/vsync go to the blue channel's control bits C0/C1; vde goes to every encoder.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level (1 = active-high)
- VS_POL, 0, vsync active level

Ports:
- PixelClk  in  1  pixel clock; only clock
- aRst_n  in  1  asynchronous active-low reset
- in_data  in  24  {R,G,B} pixel from frame buffer
- in_valid  in  1  in_data valid
- in_sof  in  1  qualifies in_data as the first pixel of a frame
- in_ready  out  1  beat consumed when in_valid&&in_ready
- out_red/out_green/out_blue  out  8 each  pixel bytes to encoders
- out_hsync  out  1  to blue encoder C0
- out_vsync  out  1  to blue encoder C1
- out_vde  out  1  video data enable
- frame_start  out  1  one-cycle pulse on first active pixel of a frame
- underflow  out  1  one-cycle pulse on pixel starvation or misalignment
- lock  out  1  high while the stream is aligned to the raster (registered state==LOCKED)

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Counters are 11 bits.
- h_cnt runs 0..H_TOTAL-1 and wraps to 0. v_cnt increments when h_cnt wraps and wraps to 0 after V_TOTAL-1.
- active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- hsync is active when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
- vsync is active when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC.
- vsync changes only on the cycle where h_cnt = 0.
- Output level of a sync signal = its POL parameter when active, ~POL otherwise.
- Latency: every output except in_ready is registered exactly 1 cycle after the counter state it reflects. Data, syncs and vde are mutually aligned.
- State machine, 2 states; reset state is WAIT_SOF.
- WAIT_SOF:
  - in_ready = in_valid && !in_sof, so non-SOF beats are drained and discarded.
  - When h_cnt=0, v_cnt=0 and in_valid&&in_sof: consume the beat (in_ready=1), output it as the first pixel, go to LOCKED.
  - Otherwise active pixels output 0x000000 with vde=1.
- LOCKED:
  - in_ready = active.
  - Active cycle with in_valid=0: output 0x000000, pulse underflow, go to WAIT_SOF.
  - Consumed beat with in_sof=1 at any position other than (0,0): pulse underflow, output the pixel, go to WAIT_SOF.
  - Consumed beat with in_sof=0 at (0,0): same handling (pulse underflow, output the pixel, go to WAIT_SOF).
- Blanking: out_red/green/blue = 0 and out_vde = 0. in_ready=0 in LOCKED.
- frame_start: registered; high together with the output of pixel (0,0) whenever LOCKED is entered or maintained there.
- Reset values:
  - counters 0; state WAIT_SOF; lock 0
  - vde 0; pixel bytes 0; frame_start 0; underflow 0
  - hsync = ~HS_POL; vsync = ~VS_POL
- Reset deasserted mid-frame: counters restart at (0,0); no partial-frame state is retained.

Optional Feature:
- Macro: VTG_COLOR_BARS_EN.
- Defined:
  - Adds input port pattern_sel (1 bit).
  - When pattern_sel=1, active pixels show 8 vertical bars, each H_ACTIVE/8 wide, in order white, yellow, cyan, green, magenta, red, blue, black (components 0xFF/0x00).
  - in_ready=0, underflow suppressed, state held in WAIT_SOF.
  - Deasserting pattern_sel resumes normal resync at the next (0,0).
- Undefined: port absent; streaming behaviour only.

Test Plan:
- Reset asserted (aRst_n=0) mid-line -> all outputs at reset values immediately; hsync/vsync = 1 with POL=0; after release, first vde=1 appears 1 cycle after the counter at (0,0).
- Free run, in_valid=0 -> hsync low for exactly 96 cycles starting at h_cnt 656; vsync low for exactly 2 lines starting at line 490; vde high for 640 cycles per line on 480 lines; period 800x525 cycles.
- Continuous stream, in_sof on first beat, pixel = {x[7:0], y[7:0], 8'hA5} -> lock rises at frame 1, frame_start aligns with pixel (0,0), every output pixel matches its coordinates, no underflow over 2 frames.
- in_valid dropped for 1 cycle at (100,20) while LOCKED -> underflow pulse, that pixel = 0, lock falls, re-lock at the next frame's (0,0).
- Misplaced in_sof at (5,0) -> underflow pulse, lock=0; non-SOF beats are drained; lock=1 at the next (0,0).
- With VTG_COLOR_BARS_EN and pattern_sel=1 -> pixel at x=0 is FFFFFF, x=80 is FFFF00, x=639 is 000000; in_ready stays 0.
